sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-requester arbiter that shares one single-port synchronous SRAM macro (`sram`: active-low write enable `nWE`, registered read data) between master 0 and master 1.
- Arbitration is round-robin, one access granted per cycle. Each master sees a req/gnt handshake plus a read-return channel with a valid strobe.
- The block sits between the SRAM and two client datapaths, e.g. a DMA engine and a CPU load/store port.

Parameters:
- AW, 2, SRAM address width; SRAM depth = 1<<AW.
- DW, 2, SRAM data width.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  master 0 access request; held until m0_gnt.
- m0_we  in  1  master 0 access type: 1 = write, 0 = read. Valid with m0_req.
- m0_adr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 request accepted this cycle (combinational).
- m0_rvalid  out  1  master 0 read data valid (registered).
- m0_rdata  out  DW  master 0 read data; meaningful only when m0_rvalid=1.
- m1_req, m1_we, m1_adr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings as the master 0 set, for master 1.
- sram_nWE  out  1  to SRAM nWE: 0 = write, 1 = read/idle.
- sram_adr  out  AW  to SRAM adr.
- sram_din  out  DW  to SRAM d_in.
- sram_dout  in  DW  from SRAM d_out.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - rr_last = 1, so master 0 has priority in the first cycle after reset.
  - m0_rvalid = m1_rvalid = 0; rd_pend = 0.
  - While rst=1: m0_gnt = m1_gnt = 0, sram_nWE = 1, sram_adr = 0, sram_din = 0.
- Arbitration (combinational, each cycle):
  - Only one req asserted -> that master is granted.
  - Both asserted -> the master other than rr_last is granted.
  - Neither asserted -> no grant.
  - At most one gnt is high in any cycle.
- Pointer update: on any grant, rr_last <= granted index at the posedge. No grant -> rr_last holds.
- SRAM drive (combinational from the granted master):
  - sram_adr = granted adr; sram_din = granted wdata; sram_nWE = ~granted we.
  - No grant -> sram_nWE = 1, sram_adr = 0, sram_din = 0. This is a harmless idle read.
- Handshake: a request is consumed at the posedge where req && gnt. The master may change or drop req/adr/we/wdata after that edge. Req held without gnt -> signals must stay stable.
- Read return pipeline:
  - On a granted read, register rd_pend = 1 and rd_tag = granted index.
  - Next cycle: m<rd_tag>_rvalid = 1 and m<rd_tag>_rdata = sram_dout.
  - Read latency is exactly 1 cycle after the grant edge.
  - Back-to-back reads, including alternating masters, return every cycle, in grant order.
- Writes produce no rvalid.
- rdata for the non-valid master is driven with sram_dout; consumers must qualify it with rvalid.
- Read-after-write to the same address:
  - Write granted in cycle N, read granted in cycle N+1 -> the read returns the new data.
  - Same-cycle conflict is impossible, since only one grant per cycle.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1,... Worst-case wait is 1 cycle.
- Reset mid-operation: a read granted in the cycle rst is sampled is dropped; no rvalid follows. rr_last returns to 1.
- Width rules: all address and data paths pass through unmodified. No arithmetic.

Decomposition:
- Shared package sram_arb_pkg: constants M0 = 0, M1 = 1, NUM_MASTERS = 2, and the we encoding (WE_WRITE = 1, WE_READ = 0).
- One natural sub-module: rr_arb2, a 2-way round-robin grant generator with pointer register (inputs req[1:0], clk, rst; output gnt[1:0]).
- The SRAM drive mux and the read-return pipeline stay in sram_arbiter.
- The bench instantiates the real sram with AW=2, DW=2.

Test Plan:
- Single master write/read: after reset, m0 writes adr=2, wdata=3 (m0_gnt=1 same cycle, sram_nWE=0). Next cycle m0 reads adr=2 -> m0_rvalid=1 one cycle after the read grant, m0_rdata=3; m1_rvalid stays 0.
- Simultaneous reads: memory preloaded adr0=1, adr1=2. m0 reads adr0 and m1 reads adr1, both req from cycle 0 -> grants m0 (c0), m1 (c1); m0_rvalid at c1 with 1, m1_rvalid at c2 with 2.
- Fairness: both masters hold continuous write requests for 8 cycles -> gnt pattern 0,1,0,1,0,1,0,1; never both high; sram_nWE=0 in all 8 cycles.
- Read-after-write: m1 writes adr3=2 in cycle N, m0 reads adr3 in cycle N+1 -> m0_rdata=2 with m0_rvalid at N+2.
- Idle: no requests for 5 cycles -> sram_nWE=1, no gnt, no rvalid; rr_last unchanged, so the next simultaneous request goes to the master not granted last.
- Reset mid-read: m0 read granted in the same cycle rst=1 -> no m0_rvalid afterwards. After rst falls, simultaneous requests are granted to m0 first.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-master SRAM arbiter.
//   M0 / M1      : master indices, also used as grant-vector bit positions
//   NUM_MASTERS  : number of requesters
//   WE_WRITE/READ: encoding of the per-master we input
package sram_arb_pkg;

  localparam logic        M0          = 1'b0;
  localparam logic        M1          = 1'b1;
  localparam int unsigned NUM_MASTERS = 2;

  localparam logic        WE_WRITE    = 1'b1;
  localparam logic        WE_READ     = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset; forces grants low
//   req : request vector, bit index = master index
//   gnt : one-hot (or zero) grant vector, combinational from req and pointer
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt
);

  // Index of the master granted most recently; the other one wins a tie.
  logic r_rr_last;

  always_comb begin
    gnt = '0;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt[M0] = 1'b1;
        2'b10:   gnt[M1] = 1'b1;
        2'b11: begin
          if (r_rr_last == M1) gnt[M0] = 1'b1;
          else                 gnt[M1] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last <= M1;
    end else if (gnt[M0]) begin
      r_rr_last <= M0;
    end else if (gnt[M1]) begin
      r_rr_last <= M1;
    end
  end

endmodule

// File: rtl/sram.sv
// Single-port synchronous SRAM macro model with registered read data.
// Ports:
//   clk   : clock, all activity on posedge
//   nWE   : active-low write enable (0 = write, 1 = read)
//   adr   : word address
//   d_in  : write data
//   d_out : read data, registered one cycle after a read; holds on write cycles
module sram #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          nWE,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (!nWE) begin
      r_mem[adr] <= d_in;
    end else begin
      d_out <= r_mem[adr];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two masters.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   mX_req/we/adr/wdata      : master X request (held until mX_gnt)
//   mX_gnt                   : master X accepted this cycle (combinational)
//   mX_rvalid, mX_rdata      : master X read return, one cycle after the read grant
//   sram_nWE/adr/din         : SRAM drive, from the granted master or idle read of 0
//   sram_dout                : SRAM registered read data
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          sram_nWE,
  output logic [AW-1:0] sram_adr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  logic [NUM_MASTERS-1:0] w_gnt;
  logic                   w_any_gnt;
  logic                   w_sel;
  logic                   w_we;
  logic                   w_rd_gnt;

  logic r_rd_pend;
  logic r_rd_tag;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req ({m1_req, m0_req}),
    .gnt (w_gnt)
  );

  assign m0_gnt    = w_gnt[M0];
  assign m1_gnt    = w_gnt[M1];
  assign w_any_gnt = |w_gnt;
  assign w_sel     = w_gnt[M1];
  assign w_we      = (w_sel == M1) ? m1_we : m0_we;
  assign w_rd_gnt  = w_any_gnt && (w_we == WE_READ);

  // With no grant the SRAM sees a harmless read of address 0.
  always_comb begin
    sram_nWE = 1'b1;
    sram_adr = '0;
    sram_din = '0;
    if (w_any_gnt) begin
      sram_nWE = ~w_we;
      sram_adr = (w_sel == M1) ? m1_adr   : m0_adr;
      sram_din = (w_sel == M1) ? m1_wdata : m0_wdata;
    end
  end

  // Read return: SRAM data appears the cycle after the grant, as does this tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_tag  <= M0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      r_rd_tag  <= w_sel;
    end
  end

  assign m0_rvalid = r_rd_pend && (r_rd_tag == M0);
  assign m1_rvalid = r_rd_pend && (r_rd_tag == M1);
  assign m0_rdata  = sram_dout;
  assign m1_rdata  = sram_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sram_nWE;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_din, sram_dout;

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .sram_nWE  (sram_nWE),
    .sram_adr  (sram_adr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  sram #(.AW(AW), .DW(DW)) u_sram (
    .clk   (clk),
    .nWE   (sram_nWE),
    .adr   (sram_adr),
    .d_in  (sram_din),
    .d_out (sram_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    gnt;
    logic          nwe;
    logic [AW-1:0] adr;
    logic [DW-1:0] din;
  } cyc_exp_t;

  typedef struct {
    logic          master;
    logic [DW-1:0] data;
  } rd_exp_t;

  cyc_exp_t cyc_q[$];
  rd_exp_t  rd_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Drive one cycle of stimulus and queue the hand-computed expectations.
  task automatic cyc(input logic r,
                     input logic q0, input logic w0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0,
                     input logic q1, input logic w1, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d1,
                     input logic [1:0] eg, input logic [DW-1:0] erd);
    cyc_exp_t e;
    rd_exp_t  rd;
    @(posedge clk);
    #1;
    rst = r;
    m0_req = q0; m0_we = w0; m0_adr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_adr = a1; m1_wdata = d1;
    e.gnt = eg;
    e.nwe = 1'b1;
    e.adr = '0;
    e.din = '0;
    if (eg == 2'b01) begin
      e.nwe = ~w0; e.adr = a0; e.din = d0;
    end else if (eg == 2'b10) begin
      e.nwe = ~w1; e.adr = a1; e.din = d1;
    end
    cyc_q.push_back(e);
    if (eg != 2'b00 && e.nwe) begin
      rd.master = eg[1];
      rd.data   = erd;
      rd_q.push_back(rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  // Monitor: per-cycle drive checks plus read-return scoreboard.
  always @(negedge clk) begin
    cyc_exp_t e;
    rd_exp_t  r;
    logic          act_m;
    logic [DW-1:0] act_d;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      n_chk++;
      if ({m1_gnt, m0_gnt} !== e.gnt) begin
        n_fail++;
        $display("FAIL gnt @%0t: got %b want %b", $time, {m1_gnt, m0_gnt}, e.gnt);
      end
      n_chk++;
      if (sram_nWE !== e.nwe) begin
        n_fail++;
        $display("FAIL sram_nWE @%0t: got %b want %b", $time, sram_nWE, e.nwe);
      end
      n_chk++;
      if (sram_adr !== e.adr || sram_din !== e.din) begin
        n_fail++;
        $display("FAIL sram_adr/din @%0t: got %0d/%0d want %0d/%0d", $time,
                 sram_adr, sram_din, e.adr, e.din);
      end
    end
    if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
      n_chk++;
      act_m = m1_rvalid;
      act_d = m1_rvalid ? m1_rdata : m0_rdata;
      if (m0_rvalid && m1_rvalid) begin
        n_fail++;
        $display("FAIL rvalid_both @%0t: got 11 want one-hot", $time);
      end else if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected @%0t: got m%0d data %0d want none", $time, act_m, act_d);
      end else begin
        r = rd_q.pop_front();
        if (act_m !== r.master || act_d !== r.data) begin
          n_fail++;
          $display("FAIL rdata @%0t: got m%0d data %0d want m%0d data %0d", $time,
                   act_m, act_d, r.master, r.data);
        end
      end
    end
  end

  initial begin
    // Reset, including requests presented while rst is high.
    cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(1'b1, 1, 1, 1, 2, 1, 0, 3, 1, 2'b00, 0);

    // Single master write then read-back.
    cyc(1'b0, 1, 1, 2, 3, 0, 0, 0, 0, 2'b01, 0);
    cyc(1'b0, 1, 0, 2, 0, 0, 0, 0, 0, 2'b01, 3);
    idle(1);

    // Preload adr0=1 (m0), adr1=2 (m1); then simultaneous reads, m0 first.
    cyc(1'b0, 1, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0);
    cyc(1'b0, 0, 0, 0, 0, 1, 1, 1, 2, 2'b10, 0);
    cyc(1'b0, 1, 0, 0, 0, 1, 0, 1, 0, 2'b01, 1);
    cyc(1'b0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b10, 2);
    idle(1);

    // Fairness: continuous writes from both; alternate starting with m0.
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] d;
      d = DW'(i);
      cyc(1'b0, 1, 1, 0, d, 1, 1, 1, ~d, (i % 2 == 0) ? 2'b01 : 2'b10, 0);
    end

    // Read-after-write across masters.
    cyc(1'b0, 0, 0, 0, 0, 1, 1, 3, 2, 2'b10, 0);
    cyc(1'b0, 1, 0, 3, 0, 0, 0, 0, 0, 2'b01, 2);

    // Idle keeps pointer at m0, so the next tie goes to m1.
    idle(5);
    cyc(1'b0, 1, 0, 3, 0, 1, 0, 3, 0, 2'b10, 2);
    cyc(1'b0, 1, 0, 3, 0, 0, 0, 0, 0, 2'b01, 2);

    // Reset with a pending m0 read: dropped, pointer back to m0 priority.
    cyc(1'b1, 1, 0, 2, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(1'b0, 1, 0, 2, 0, 1, 0, 3, 0, 2'b01, 3);
    cyc(1'b0, 0, 0, 0, 0, 1, 0, 3, 0, 2'b10, 2);
    idle(3);

    @(posedge clk);
    #1;
    n_chk++;
    if (rd_q.size() != 0 || cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d reads %0d cycles outstanding want 0 0",
               rd_q.size(), cyc_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
